pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg_pkg.sv | 40 ++++
 rtl/pipe_skid_reg_if.sv | 24 ++
 rtl/pipe_skid_reg_entry.sv | 43 ++++
 rtl/pipe_skid_reg.sv | 136 +++++++++++++
 tb/tb_pipe_skid_reg.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// rtl/pipe_skid_reg_pkg.sv - shared pipeline control-field layout and stage helpers
package pipe_skid_reg_pkg;

    // Control-field layout of a decoded instruction; the skid stage itself treats ctrl as opaque.
    localparam int CTRL_FIELD_W = 16;
    localparam int ALU_OP_LSB   = 0;
    localparam int ALU_OP_W     = 4;
    localparam int RD_LSB       = 4;
    localparam int RD_W         = 5;
    localparam int FLAG_LSB     = 9;
    localparam int NUM_FLAGS    = 7;
    localparam int LD_BIT       = 9;
    localparam int STR_BIT      = 10;
    localparam int BYT_BIT      = 11;
    localparam int WE_BIT       = 12;
    localparam int MUL_BIT      = 13;
    localparam int BRN_BIT      = 14;
    localparam int BP_TAKEN_BIT = 15;

    // Source selected for the main entry when it loads.
    typedef enum logic {
        SRC_IN   = 1'b0,
        SRC_SKID = 1'b1
    } main_src_e;

    // Assemble a control word from its fields; flags are ordered ld,str,byt,we,mul,brn,bp_taken.
    function automatic logic [CTRL_FIELD_W-1:0] pack_ctrl(
        input logic [ALU_OP_W-1:0]  alu_op,
        input logic [RD_W-1:0]      rd,
        input logic [NUM_FLAGS-1:0] flags
    );
        logic [CTRL_FIELD_W-1:0] c;
        c = '0;
        c[ALU_OP_LSB +: ALU_OP_W] = alu_op;
        c[RD_LSB +: RD_W]         = rd;
        c[FLAG_LSB +: NUM_FLAGS]  = flags;
        return c;
    endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// rtl/pipe_skid_reg_if.sv - upstream/downstream handshake bundle of the skid stage
interface pipe_skid_reg_if #(
    parameter int PAYLOAD_W = 128,
    parameter int CTRL_W    = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [CTRL_W-1:0]    in_ctrl;
    logic                 out_valid;
    logic                 out_ready;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [CTRL_W-1:0]    out_ctrl;

    modport slave (
        input  in_valid, in_payload, in_ctrl, out_ready,
        output in_ready, out_valid, out_payload, out_ctrl
    );

    modport master (
        output in_valid, in_payload, in_ctrl, out_ready,
        input  in_ready, out_valid, out_payload, out_ctrl
    );
endinterface

// File: rtl/pipe_skid_reg_entry.sv
// rtl/pipe_skid_reg_entry.sv - one pipeline entry: valid + payload + ctrl with load/clear
module pipe_skid_entry #(
    parameter int PAYLOAD_W  = 128,
    parameter int CTRL_W     = 16,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 clr_i,
    input  logic [PAYLOAD_W-1:0] payload_i,
    input  logic [CTRL_W-1:0]    ctrl_i,
    output logic                 valid_o,
    output logic [PAYLOAD_W-1:0] payload_o,
    output logic [CTRL_W-1:0]    ctrl_o
);
    logic                 valid_q;
    logic [PAYLOAD_W-1:0] payload_q;
    logic [CTRL_W-1:0]    ctrl_q;

    // Clear wins over load; ctrl always zeroes on invalidate, payload only when CLEAR_DATA is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
            ctrl_q    <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            if (CLEAR_DATA) begin
                payload_q <= '0;
            end
        end else if (load_i) begin
            valid_q   <= 1'b1;
            payload_q <= payload_i;
            ctrl_q    <= ctrl_i;
        end
    end

    assign valid_o   = valid_q;
    assign payload_o = payload_q;
    assign ctrl_o    = ctrl_q;
endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry registered skid stage between decode and execute
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int PAYLOAD_W  = 128,
    parameter int CTRL_W     = 16,
    parameter bit CLEAR_DATA = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_skid_reg_if.slave    bus,
    input  logic              flush,
    input  logic              clr_cnt,
    output logic [1:0]        occ,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                 main_valid, skid_valid;
    logic [PAYLOAD_W-1:0] main_payload, skid_payload, main_din_payload;
    logic [CTRL_W-1:0]    main_ctrl, skid_ctrl, main_din_ctrl;
    logic                 main_load, main_clr, skid_load, skid_clr;
    main_src_e            main_src;
    logic                 main_valid_d, skid_valid_d;
    logic                 in_ready_q, in_ready_d;
    logic [1:0]           occ_q, occ_d;
    logic [CNT_W-1:0]     stall_q, stall_d;
    logic                 accept, consume;

    assign accept  = bus.in_valid & in_ready_q;
    assign consume = main_valid & bus.out_ready;

    // Decide entry moves; skid only ever holds the younger entry, so FIFO order is preserved.
    always_comb begin
        main_load = 1'b0;
        main_clr  = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        main_src  = SRC_IN;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (consume && skid_valid) begin
            main_load = 1'b1;
            main_src  = SRC_SKID;
            skid_load = accept;
            skid_clr  = ~accept;
        end else if (consume || !main_valid) begin
            main_load = accept;
            main_clr  = ~accept;
        end else begin
            skid_load = accept;
        end
    end

    assign main_din_payload = (main_src == SRC_SKID) ? skid_payload : bus.in_payload;
    assign main_din_ctrl    = (main_src == SRC_SKID) ? skid_ctrl    : bus.in_ctrl;

    pipe_skid_entry #(
        .PAYLOAD_W (PAYLOAD_W),
        .CTRL_W    (CTRL_W),
        .CLEAR_DATA(CLEAR_DATA)
    ) u_main (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (main_load),
        .clr_i    (main_clr),
        .payload_i(main_din_payload),
        .ctrl_i   (main_din_ctrl),
        .valid_o  (main_valid),
        .payload_o(main_payload),
        .ctrl_o   (main_ctrl)
    );

    pipe_skid_entry #(
        .PAYLOAD_W (PAYLOAD_W),
        .CTRL_W    (CTRL_W),
        .CLEAR_DATA(CLEAR_DATA)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (skid_load),
        .clr_i    (skid_clr),
        .payload_i(bus.in_payload),
        .ctrl_i   (bus.in_ctrl),
        .valid_o  (skid_valid),
        .payload_o(skid_payload),
        .ctrl_o   (skid_ctrl)
    );

    // Next-state valids feed registered in_ready and occ so neither depends on out_ready combinationally.
    always_comb begin
        main_valid_d = main_load | (main_valid & ~main_clr);
        skid_valid_d = skid_load | (skid_valid & ~skid_clr);
        in_ready_d   = ~skid_valid_d;
        occ_d        = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
    end

    // Occupancy and upstream ready registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q <= 1'b1;
            occ_q      <= 2'd0;
        end else begin
            in_ready_q <= in_ready_d;
            occ_q      <= occ_d;
        end
    end

    // Saturating stall counter; clear wins over increment.
    always_comb begin
        stall_d = stall_q;
        if (clr_cnt) begin
            stall_d = '0;
        end else if (main_valid && !bus.out_ready && stall_q != CNT_MAX) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = main_valid;
    assign bus.out_payload = main_payload;
    assign bus.out_ctrl    = main_ctrl;
    assign occ             = occ_q;
    assign stall_cnt       = stall_q;
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - table, directed and randomized checks of pipe_skid_reg
module tb_pipe_skid_reg;
    import pipe_skid_reg_pkg::*;

    localparam int PW   = 32;
    localparam int CW   = 16;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            clr_cnt = 1'b0;
    logic [1:0]      occ;
    logic [CNTW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_skid_reg_if #(.PAYLOAD_W(PW), .CTRL_W(CW)) bus ();

    pipe_skid_reg #(
        .PAYLOAD_W (PW),
        .CTRL_W    (CW),
        .CLEAR_DATA(1'b1),
        .CNT_W     (CNTW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .flush    (flush),
        .clr_cnt  (clr_cnt),
        .occ      (occ),
        .stall_cnt(stall_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: an ordered queue of at most two held payloads plus a stall count.
    logic [PW-1:0] mq[$];
    int            m_cnt = 0;

    typedef struct {
        logic          iv;
        logic [PW-1:0] p;
        logic          ordy;
        logic          fl;
        logic          clr;
        logic          ev;
        logic [PW-1:0] ep;
        logic [1:0]    eocc;
        logic          erdy;
        int            est;
    } vec_t;

    vec_t tbl[15];

    function automatic logic [CW-1:0] ctrl_of(input logic [PW-1:0] p);
        return pack_ctrl(p[3:0], p[8:4], p[15:9]) ^ p[31:16];
    endfunction

    function automatic vec_t mk(input logic iv, input logic [PW-1:0] p, input logic ordy,
                                input logic fl, input logic clr, input logic ev,
                                input logic [PW-1:0] ep, input logic [1:0] eocc,
                                input logic erdy, input int est);
        vec_t v;
        v.iv = iv; v.p = p; v.ordy = ordy; v.fl = fl; v.clr = clr;
        v.ev = ev; v.ep = ep; v.eocc = eocc; v.erdy = erdy; v.est = est;
        return v;
    endfunction

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic          ev;
        logic [PW-1:0] ep;
        ev = (mq.size() > 0);
        ep = ev ? mq[0] : '0;
        chk("out_valid", PW'(bus.out_valid), PW'(ev));
        chk("out_payload", bus.out_payload, ep);
        chk("out_ctrl", PW'(bus.out_ctrl), ev ? PW'(ctrl_of(ep)) : '0);
        chk("occ", PW'(occ), PW'(mq.size()));
        chk("in_ready", PW'(bus.in_ready), PW'(mq.size() < 2));
        chk("stall_cnt", PW'(stall_cnt), PW'(m_cnt));
    endtask

    // Drive one cycle, advance the model across the edge, then compare away from the edge.
    task automatic step(input logic iv, input logic [PW-1:0] p, input logic ordy,
                        input logic fl, input logic clr);
        logic pre_valid, pre_ready;
        bus.in_valid   = iv;
        bus.in_payload = p;
        bus.in_ctrl    = ctrl_of(p);
        bus.out_ready  = ordy;
        flush          = fl;
        clr_cnt        = clr;
        @(posedge clk);
        pre_valid = (mq.size() > 0);
        pre_ready = (mq.size() < 2);
        if (clr) m_cnt = 0;
        else if (pre_valid && !ordy && m_cnt < CMAX) m_cnt++;
        if (fl) begin
            mq.delete();
        end else begin
            if (pre_valid && ordy) void'(mq.pop_front());
            if (iv && pre_ready) mq.push_back(p);
        end
        #1;
        check_model();
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_payload = '0;
        bus.in_ctrl    = '0;
        bus.out_ready  = 1'b0;

        // Table: stall/release ordering, accept+consume with occ=1, flush with occ=2, counter clear.
        tbl[0]  = mk(1, 32'hA, 0, 0, 0, 1, 32'hA, 1, 1, 0);
        tbl[1]  = mk(1, 32'hB, 0, 0, 0, 1, 32'hA, 2, 0, 1);
        tbl[2]  = mk(1, 32'hC, 0, 0, 0, 1, 32'hA, 2, 0, 2);
        tbl[3]  = mk(1, 32'hC, 0, 0, 0, 1, 32'hA, 2, 0, 3);
        tbl[4]  = mk(0, 32'h0, 1, 0, 0, 1, 32'hB, 1, 1, 3);
        tbl[5]  = mk(1, 32'hC, 1, 0, 0, 1, 32'hC, 1, 1, 3);
        tbl[6]  = mk(0, 32'h0, 1, 0, 0, 0, 32'h0, 0, 1, 3);
        tbl[7]  = mk(1, 32'h4, 0, 0, 0, 1, 32'h4, 1, 1, 3);
        tbl[8]  = mk(1, 32'h5, 1, 0, 0, 1, 32'h5, 1, 1, 3);
        tbl[9]  = mk(0, 32'h0, 1, 0, 0, 0, 32'h0, 0, 1, 3);
        tbl[10] = mk(1, 32'h6, 0, 0, 0, 1, 32'h6, 1, 1, 3);
        tbl[11] = mk(1, 32'h7, 0, 0, 0, 1, 32'h6, 2, 0, 4);
        tbl[12] = mk(1, 32'h8, 0, 1, 0, 0, 32'h0, 0, 1, 5);
        tbl[13] = mk(0, 32'h0, 1, 0, 0, 0, 32'h0, 0, 1, 5);
        tbl[14] = mk(0, 32'h0, 1, 0, 1, 0, 32'h0, 0, 1, 0);

        // Reset state while held in reset.
        @(negedge clk);
        @(negedge clk);
        check_model();
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].iv, tbl[i].p, tbl[i].ordy, tbl[i].fl, tbl[i].clr);
            chk($sformatf("tbl%0d.valid", i), PW'(bus.out_valid), PW'(tbl[i].ev));
            chk($sformatf("tbl%0d.payload", i), bus.out_payload, tbl[i].ep);
            chk($sformatf("tbl%0d.occ", i), PW'(occ), PW'(tbl[i].eocc));
            chk($sformatf("tbl%0d.in_ready", i), PW'(bus.in_ready), PW'(tbl[i].erdy));
            chk($sformatf("tbl%0d.stall", i), PW'(stall_cnt), PW'(tbl[i].est));
        end

        // Streaming with out_ready held high: one-cycle latency, occ=1, no stalls.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'h100 + i, 1'b1, 1'b0, 1'b0);
            chk("stream.payload", bus.out_payload, 32'h100 + i);
            chk("stream.occ", PW'(occ), 32'd1);
            chk("stream.stall", PW'(stall_cnt), 32'd0);
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Saturation of the narrow stall counter, then clear.
        step(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("sat.stall", PW'(stall_cnt), PW'(CMAX));
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("sat.clear", PW'(stall_cnt), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0));
        end
        step(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // Asynchronous reset mid-cycle with two entries held.
        step(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
        chk("arst.pre_occ", PW'(occ), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        m_cnt = 0;
        check_model();
        @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("arst.no_pulse", PW'(bus.out_valid), 32'd0);
        step(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
        chk("arst.first_accept", bus.out_payload, 32'h33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
